fetch_issue_stage: RTL and testbench

//   Single-cycle fetch/decode stage directly upstream of the hazard unit. Owns the PC, reads

---
 rtl/fetch_issue_stage_pkg.sv | 35 +++
 rtl/fetch_issue_stage_decoder.sv | 42 ++++
 rtl/fetch_issue_stage.sv | 106 ++++++++++
 tb/tb_fetch_issue_stage.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/fetch_issue_stage_pkg.sv
// Shared types, opcodes and field helpers
// for the fetch/issue stage.
package fetch_issue_stage_pkg;

  typedef logic [31:0] addr_t;
  typedef logic [31:0] word_t;
  typedef logic [4:0]  regid_t;

  localparam word_t NOP = 32'h0000_0013;

  typedef enum logic [6:0] {
    OPC_LUI    = 7'b0110111,
    OPC_AUIPC  = 7'b0010111,
    OPC_JAL    = 7'b1101111,
    OPC_JALR   = 7'b1100111,
    OPC_BRANCH = 7'b1100011,
    OPC_LOAD   = 7'b0000011,
    OPC_STORE  = 7'b0100011,
    OPC_OP_IMM = 7'b0010011,
    OPC_OP     = 7'b0110011
  } opcode_e;

  function automatic regid_t get_rs1(word_t i);
    return i[19:15];
  endfunction

  function automatic regid_t get_rs2(word_t i);
    return i[24:20];
  endfunction

  function automatic regid_t get_rd(word_t i);
    return i[11:7];
  endfunction

endpackage

// File: rtl/fetch_issue_stage_decoder.sv
// Opcode -> register usage flags, so unused
// instruction fields never cause false stalls.
module rv_reg_usage_decoder
  import fetch_issue_stage_pkg::*;
(
  input  logic [6:0] i_opc,
  output logic       o_uses_rs1,
  output logic       o_uses_rs2,
  output logic       o_writes_rd
);

  always_comb begin
    o_uses_rs1  = 1'b0;
    o_uses_rs2  = 1'b0;
    o_writes_rd = 1'b0;
    unique case (1'b1)
      (i_opc == OPC_LUI),
      (i_opc == OPC_AUIPC),
      (i_opc == OPC_JAL): begin
        o_writes_rd = 1'b1;
      end
      (i_opc == OPC_JALR),
      (i_opc == OPC_LOAD),
      (i_opc == OPC_OP_IMM): begin
        o_uses_rs1  = 1'b1;
        o_writes_rd = 1'b1;
      end
      (i_opc == OPC_BRANCH),
      (i_opc == OPC_STORE): begin
        o_uses_rs1 = 1'b1;
        o_uses_rs2 = 1'b1;
      end
      (i_opc == OPC_OP): begin
        o_uses_rs1  = 1'b1;
        o_uses_rs2  = 1'b1;
        o_writes_rd = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/fetch_issue_stage.sv
// Fetch/decode stage: owns the PC, feeds the
// hazard unit and issues into execute.
module fetch_issue_stage
  import fetch_issue_stage_pkg::*;
#(
  parameter addr_t RESET_PC  = 32'h0000_0000,
  parameter word_t NOP_INSTR = NOP
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic [4:0]  hz_rs1,
  output logic [4:0]  hz_rs2,
  output logic [4:0]  hz_rd,
  output logic [31:0] hz_pc,
  input  logic        hz_stall,
  input  logic        hz_fwd1,
  input  logic        hz_fwd2,
  input  logic [31:0] rf_rs1_data,
  input  logic [31:0] rf_rs2_data,
  input  logic [31:0] fwd_data,
  output logic        ex_valid,
  output logic [31:0] ex_pc,
  output logic [31:0] ex_instr,
  output logic [31:0] ex_op1,
  output logic [31:0] ex_op2
);

  addr_t  r_pc;
  logic   r_ex_valid;
  addr_t  r_ex_pc;
  word_t  r_ex_instr;
  word_t  r_ex_op1;
  word_t  r_ex_op2;

  logic   w_uses_rs1;
  logic   w_uses_rs2;
  logic   w_writes_rd;
  logic   w_live;
  regid_t w_rs1;
  regid_t w_rs2;
  regid_t w_rd;
  word_t  w_op1;
  word_t  w_op2;

  rv_reg_usage_decoder u_dec (
    .i_opc       (imem_data[6:0]),
    .o_uses_rs1  (w_uses_rs1),
    .o_uses_rs2  (w_uses_rs2),
    .o_writes_rd (w_writes_rd)
  );

  assign w_rs1 = w_uses_rs1  ? get_rs1(imem_data) : '0;
  assign w_rs2 = w_uses_rs2  ? get_rs2(imem_data) : '0;
  assign w_rd  = w_writes_rd ? get_rd(imem_data)  : '0;

  // Squashed or reset slots must leave no hazard history
  assign w_live = rst_n && !redirect_valid;

  assign imem_addr = r_pc;
  assign hz_pc     = r_pc;
  assign hz_rs1    = w_live ? w_rs1 : '0;
  assign hz_rs2    = w_live ? w_rs2 : '0;
  assign hz_rd     = w_live ? w_rd  : '0;

  assign w_op1 = (w_rs1 == '0) ? '0 :
                 (hz_fwd1 ? fwd_data : rf_rs1_data);
  assign w_op2 = (w_rs2 == '0) ? '0 :
                 (hz_fwd2 ? fwd_data : rf_rs2_data);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_pc       <= RESET_PC;
      r_ex_valid <= 1'b0;
      r_ex_pc    <= '0;
      r_ex_instr <= NOP_INSTR;
      r_ex_op1   <= '0;
      r_ex_op2   <= '0;
    end else if (redirect_valid || hz_stall) begin
      if (redirect_valid)
        r_pc <= redirect_pc & ~32'h3;
      r_ex_valid <= 1'b0;
      r_ex_pc    <= r_pc;
      r_ex_instr <= NOP_INSTR;
      r_ex_op1   <= '0;
      r_ex_op2   <= '0;
    end else begin
      r_pc       <= r_pc + 32'd4;
      r_ex_valid <= 1'b1;
      r_ex_pc    <= r_pc;
      r_ex_instr <= imem_data;
      r_ex_op1   <= w_op1;
      r_ex_op2   <= w_op2;
    end
  end

  assign ex_valid = r_ex_valid;
  assign ex_pc    = r_ex_pc;
  assign ex_instr = r_ex_instr;
  assign ex_op1   = r_ex_op1;
  assign ex_op2   = r_ex_op2;

endmodule

// File: tb/tb_fetch_issue_stage.sv
// Directed vector bench for fetch_issue_stage.
// Expected values are hand-computed per vector.
module tb_fetch_issue_stage;

  logic        clk;
  logic        rst_n;
  logic [31:0] imem_addr;
  logic [31:0] imem_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [4:0]  hz_rs1;
  logic [4:0]  hz_rs2;
  logic [4:0]  hz_rd;
  logic [31:0] hz_pc;
  logic        hz_stall;
  logic        hz_fwd1;
  logic        hz_fwd2;
  logic [31:0] rf_rs1_data;
  logic [31:0] rf_rs2_data;
  logic [31:0] fwd_data;
  logic        ex_valid;
  logic [31:0] ex_pc;
  logic [31:0] ex_instr;
  logic [31:0] ex_op1;
  logic [31:0] ex_op2;

  int total = 0;
  int bad   = 0;

  fetch_issue_stage dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_addr      (imem_addr),
    .imem_data      (imem_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .hz_rs1         (hz_rs1),
    .hz_rs2         (hz_rs2),
    .hz_rd          (hz_rd),
    .hz_pc          (hz_pc),
    .hz_stall       (hz_stall),
    .hz_fwd1        (hz_fwd1),
    .hz_fwd2        (hz_fwd2),
    .rf_rs1_data    (rf_rs1_data),
    .rf_rs2_data    (rf_rs2_data),
    .fwd_data       (fwd_data),
    .ex_valid       (ex_valid),
    .ex_pc          (ex_pc),
    .ex_instr       (ex_instr),
    .ex_op1         (ex_op1),
    .ex_op2         (ex_op2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] st;
    logic [31:0] rv;
    logic [31:0] rpc;
    logic [31:0] f1;
    logic [31:0] f2;
    logic [31:0] rf1;
    logic [31:0] rf2;
    logic [31:0] fd;
    logic [31:0] e_rs1;
    logic [31:0] e_rs2;
    logic [31:0] e_rd;
    logic [31:0] npc;
    logic [31:0] ev;
    logic [31:0] epc;
    logic [31:0] ein;
    logic [31:0] eo1;
    logic [31:0] eo2;
  } vec_t;

  localparam int NV = 11;
  vec_t vt [NV];

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic idle_inputs();
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    hz_stall       = 1'b0;
    hz_fwd1        = 1'b0;
    hz_fwd2        = 1'b0;
    rf_rs1_data    = '0;
    rf_rs2_data    = '0;
    fwd_data       = '0;
  endtask

  initial begin
    // pc instr st rv rpc f1 f2 rf1 rf2 fd | rs1 rs2 rd npc ev epc ein op1 op2
    vt[0]  = '{32'h0, 32'h00500093, 0, 0, 0, 0, 0,
               32'h11, 32'h22, 0,
               0, 0, 1, 32'h4, 1, 32'h0, 32'h00500093, 0, 0};
    vt[1]  = '{32'h4, 32'h00108113, 0, 0, 0, 1, 0,
               32'h5, 32'h9, 32'hDEADBEEF,
               1, 0, 2, 32'h8, 1, 32'h4, 32'h00108113,
               32'hDEADBEEF, 0};
    vt[2]  = '{32'h8, 32'h00210193, 1, 0, 0, 0, 0,
               32'h7, 0, 0,
               2, 0, 3, 32'h8, 0, 32'h8, 32'h13, 0, 0};
    vt[3]  = '{32'h8, 32'h00210193, 0, 0, 0, 0, 0,
               32'h7, 0, 0,
               2, 0, 3, 32'hC, 1, 32'h8, 32'h00210193, 32'h7, 0};
    vt[4]  = '{32'hC, 32'h00208233, 0, 0, 0, 0, 1,
               32'hA, 32'hB, 32'hCAFE,
               1, 2, 4, 32'h10, 1, 32'hC, 32'h00208233,
               32'hA, 32'hCAFE};
    vt[5]  = '{32'h10, 32'h0020A023, 0, 0, 0, 0, 0,
               32'h1, 32'h2, 0,
               1, 2, 0, 32'h14, 1, 32'h10, 32'h0020A023, 32'h1, 32'h2};
    vt[6]  = '{32'h14, 32'h00300063, 0, 0, 0, 1, 0,
               32'h99, 32'h33, 32'h55,
               0, 3, 0, 32'h18, 1, 32'h14, 32'h00300063, 0, 32'h33};
    vt[7]  = '{32'h18, 32'h123452B7, 0, 0, 0, 0, 0,
               32'h77, 32'h88, 0,
               0, 0, 5, 32'h1C, 1, 32'h18, 32'h123452B7, 0, 0};
    vt[8]  = '{32'h1C, 32'h00208233, 1, 1, 32'h102, 0, 0,
               32'h1, 32'h2, 0,
               0, 0, 0, 32'h100, 0, 32'h1C, 32'h13, 0, 0};
    vt[9]  = '{32'h100, 32'h00500093, 0, 1, 32'hFFFFFFFE, 0, 0,
               0, 0, 0,
               0, 0, 0, 32'hFFFFFFFC, 0, 32'h100, 32'h13, 0, 0};
    vt[10] = '{32'hFFFFFFFC, 32'h00500093, 0, 0, 0, 0, 0,
               0, 0, 0,
               0, 0, 1, 32'h0, 1, 32'hFFFFFFFC, 32'h00500093, 0, 0};

    // reset held two cycles with a live instruction on the bus
    idle_inputs();
    rst_n     = 1'b0;
    imem_data = 32'h00500093;
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("rst_imem_addr", imem_addr, 32'h0);
    chk("rst_ex_valid", 32'(ex_valid), 32'h0);
    chk("rst_ex_instr", ex_instr, 32'h13);
    chk("rst_ex_pc", ex_pc, 32'h0);
    chk("rst_hz_rd", 32'(hz_rd), 32'h0);
    chk("rst_hz_rs1", 32'(hz_rs1), 32'h0);
    rst_n = 1'b1;

    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      imem_data      = vt[i].instr;
      hz_stall       = vt[i].st[0];
      redirect_valid = vt[i].rv[0];
      redirect_pc    = vt[i].rpc;
      hz_fwd1        = vt[i].f1[0];
      hz_fwd2        = vt[i].f2[0];
      rf_rs1_data    = vt[i].rf1;
      rf_rs2_data    = vt[i].rf2;
      fwd_data       = vt[i].fd;
      #1;
      chk($sformatf("v%0d_imem_addr", i), imem_addr, vt[i].pc);
      chk($sformatf("v%0d_hz_pc", i), hz_pc, vt[i].pc);
      chk($sformatf("v%0d_hz_rs1", i), 32'(hz_rs1), vt[i].e_rs1);
      chk($sformatf("v%0d_hz_rs2", i), 32'(hz_rs2), vt[i].e_rs2);
      chk($sformatf("v%0d_hz_rd", i), 32'(hz_rd), vt[i].e_rd);
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_next_pc", i), imem_addr, vt[i].npc);
      chk($sformatf("v%0d_ex_valid", i), 32'(ex_valid), vt[i].ev);
      chk($sformatf("v%0d_ex_pc", i), ex_pc, vt[i].epc);
      chk($sformatf("v%0d_ex_instr", i), ex_instr, vt[i].ein);
      chk($sformatf("v%0d_ex_op1", i), ex_op1, vt[i].eo1);
      chk($sformatf("v%0d_ex_op2", i), ex_op2, vt[i].eo2);
    end

    // reset asserted during a stall+redirect: reset must win
    @(negedge clk);
    imem_data      = 32'h00500093;
    hz_stall       = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h200;
    rst_n          = 1'b0;
    #1;
    chk("mid_rst_hz_rd", 32'(hz_rd), 32'h0);
    @(posedge clk);
    #1;
    chk("mid_rst_pc", imem_addr, 32'h0);
    chk("mid_rst_ex_valid", 32'(ex_valid), 32'h0);
    chk("mid_rst_ex_instr", ex_instr, 32'h13);

    // first cycle after reset issues normally from RESET_PC
    @(negedge clk);
    idle_inputs();
    rst_n       = 1'b1;
    imem_data   = 32'h00108113;
    rf_rs1_data = 32'h42;
    #1;
    chk("post_rst_hz_rs1", 32'(hz_rs1), 32'h1);
    @(posedge clk);
    #1;
    chk("post_rst_pc", imem_addr, 32'h4);
    chk("post_rst_ex_valid", 32'(ex_valid), 32'h1);
    chk("post_rst_ex_pc", ex_pc, 32'h0);
    chk("post_rst_ex_op1", ex_op1, 32'h42);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
